// File: rtl/cpu_controller_if.sv
// Decode bus between the 19-bit datapath and cpu_controller.
// master: datapath side (drives the instruction); slave: controller side.
interface cpu_controller_if;
  logic [18:0] allBits;
  logic [1:0]  selectToWrite;
  logic        selectR2;
  logic        selectAluArg;
  logic [2:0]  ALUfunction;
  logic [1:0]  sh_roFunction;
  logic        STM;
  logic        LDM;
  logic        enablePC;
  logic        enableZero;
  logic        enableCarry;
  logic        memRead;

  modport master (
    output allBits,
    input  selectToWrite, selectR2, selectAluArg,
    input  ALUfunction, sh_roFunction,
    input  STM, LDM, enablePC,
    input  enableZero, enableCarry, memRead
  );

  modport slave (
    input  allBits,
    output selectToWrite, selectR2, selectAluArg,
    output ALUfunction, sh_roFunction,
    output STM, LDM, enablePC,
    output enableZero, enableCarry, memRead
  );
endinterface

// File: rtl/cpu_controller.sv
// Combinational instruction decode gated by a clocked run/halt state.
// Optional HALT_EN: 19'h7FFFF halts the core until rst.
module cpu_controller (
  input  logic             clk,
  input  logic             rst,
  cpu_controller_if.slave  bus
);

`ifdef HALT_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } state_t;
`else
  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;
`endif

  state_t r_state;

  logic [18:0] w_insn;
  logic        w_run;
  logic        w_is_alu;
  logic        w_is_mem;
  logic        w_is_sh;
  logic        w_halt_insn;
  logic        w_unused;

  logic [1:0]  w_sel_wr;
  logic        w_sel_r2;
  logic        w_sel_arg;
  logic [2:0]  w_alu_fn;
  logic [1:0]  w_sh_fn;
  logic        w_stm;
  logic        w_ldm;
  logic        w_en_pc;
  logic        w_en_z;
  logic        w_en_c;
  logic        w_mem_rd;

  assign w_insn   = bus.allBits;
  assign w_is_alu = ~w_insn[18];
  assign w_is_mem = (w_insn[18:15] == 4'b1000);
  assign w_is_sh  = (w_insn[18:16] == 3'b110);
  assign w_unused = ^w_insn[13:0];

`ifdef HALT_EN
  assign w_halt_insn = (w_insn == 19'h7FFFF);
`else
  assign w_halt_insn = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: r_state <= ST_RUN;
`ifdef HALT_EN
        ST_RUN:  if (w_halt_insn) r_state <= ST_HALT;
        ST_HALT: r_state <= ST_HALT;
`else
        ST_RUN:  r_state <= ST_RUN;
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_run = (r_state == ST_RUN) & ~rst;

  always_comb begin
    w_sel_wr  = 2'b00;
    w_sel_r2  = 1'b0;
    w_sel_arg = 1'b0;
    w_alu_fn  = 3'b000;
    w_sh_fn   = 2'b00;
    w_stm     = 1'b0;
    w_ldm     = 1'b0;
    w_en_pc   = ~w_halt_insn;
    w_en_z    = 1'b0;
    w_en_c    = 1'b0;
    w_mem_rd  = 1'b0;
    unique case (1'b1)
      w_is_alu: begin
        w_alu_fn  = w_insn[16:14];
        w_sel_arg = w_insn[17];
        w_ldm     = 1'b1;
        w_en_z    = 1'b1;
        // only the add/sub family produces a carry
        w_en_c    = ~w_insn[16];
      end
      w_is_mem: begin
        w_sel_arg = 1'b1;
        if (w_insn[14]) begin
          w_stm    = 1'b1;
          w_sel_r2 = 1'b1;
        end else begin
          w_mem_rd = 1'b1;
          w_ldm    = 1'b1;
          w_sel_wr = 2'b10;
        end
      end
      w_is_sh: begin
        w_sh_fn  = w_insn[15:14];
        w_sel_wr = 2'b01;
        w_ldm    = 1'b1;
        w_en_z   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.selectToWrite = w_run ? w_sel_wr : 2'b00;
  assign bus.selectR2      = w_run & w_sel_r2;
  assign bus.selectAluArg  = w_run & w_sel_arg;
  assign bus.ALUfunction   = w_run ? w_alu_fn : 3'b000;
  assign bus.sh_roFunction = w_run ? w_sh_fn : 2'b00;
  assign bus.STM           = w_run & w_stm;
  assign bus.LDM           = w_run & w_ldm;
  assign bus.enablePC      = w_run & w_en_pc;
  assign bus.enableZero    = w_run & w_en_z;
  assign bus.enableCarry   = w_run & w_en_c;
  assign bus.memRead       = w_run & w_mem_rd;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller.
// Output vector: {sTW[2],R2,Arg,ALU[3],sh[2],STM,LDM,PC,Z,C,mR}.
module tb_cpu_controller;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  cpu_controller_if bus ();

  cpu_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [18:0] I_ADD  = 19'b0000010010101100000;
  localparam logic [18:0] I_MASK = 19'b0111111110000010000;
  localparam logic [18:0] I_SH3  = 19'b1101100110001000000;
  localparam logic [18:0] I_LDM  = 19'b1000010010100010000;
  localparam logic [18:0] I_STM  = 19'b1000110010100010000;
  localparam logic [18:0] I_HALT = 19'h7FFFF;

  localparam logic [14:0] E_ZERO = 15'b00_0_0_000_00_0_0_0_0_0_0;
  localparam logic [14:0] E_NOP  = 15'b00_0_0_000_00_0_0_1_0_0_0;
  localparam logic [14:0] E_ADD  = 15'b00_0_0_000_00_0_1_1_1_1_0;
  localparam logic [14:0] E_MASK = 15'b00_0_1_111_00_0_1_1_1_0_0;
  localparam logic [14:0] E_SH3  = 15'b01_0_0_000_11_0_1_1_1_0_0;
  localparam logic [14:0] E_LDM  = 15'b10_0_1_000_00_0_1_1_0_0_1;
  localparam logic [14:0] E_STM  = 15'b00_1_1_000_00_1_0_1_0_0_0;

  function automatic logic [14:0] outs();
    return {bus.selectToWrite, bus.selectR2, bus.selectAluArg,
            bus.ALUfunction, bus.sh_roFunction, bus.STM, bus.LDM,
            bus.enablePC, bus.enableZero, bus.enableCarry,
            bus.memRead};
  endfunction

  task automatic test_reset();
    logic [18:0] v [3];
    v = '{I_ADD, I_MASK, I_LDM};
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.allBits = v[i];
      #1;
      total++;
      if (outs() !== E_ZERO) begin
        bad++;
        $display("FAIL reset_hold[%0d] got=%b exp=%b", i, outs(), E_ZERO);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    bus.allBits = I_ADD;
    #1;
    total++;
    if (outs() !== E_ZERO) begin
      bad++;
      $display("FAIL reset_first_cycle got=%b exp=%b", outs(), E_ZERO);
    end
    @(posedge clk);
    #1;
    total++;
    if (outs() !== E_ADD) begin
      bad++;
      $display("FAIL reset_run got=%b exp=%b", outs(), E_ADD);
    end
  endtask

  task automatic test_alu();
    logic [18:0] v [5];
    logic [14:0] e [5];
    v = '{I_ADD, I_MASK,
          19'b00_011_00000000000000,
          19'b00_100_00000000000000,
          19'b01_010_00000000000000};
    e = '{E_ADD, E_MASK,
          15'b00_0_0_011_00_0_1_1_1_1_0,
          15'b00_0_0_100_00_0_1_1_1_0_0,
          15'b00_0_1_010_00_0_1_1_1_1_0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.allBits = v[i];
      #1;
      total++;
      if (outs() !== e[i]) begin
        bad++;
        $display("FAIL alu[%0d] got=%b exp=%b", i, outs(), e[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic [18:0] v [2];
    logic [14:0] e [2];
    v = '{I_SH3, 19'b110_01_00000000000000};
    e = '{E_SH3, 15'b01_0_0_000_01_0_1_1_1_0_0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.allBits = v[i];
      #1;
      total++;
      if (outs() !== e[i]) begin
        bad++;
        $display("FAIL shift[%0d] got=%b exp=%b", i, outs(), e[i]);
      end
    end
  endtask

  task automatic test_mem();
    logic [18:0] v [2];
    logic [14:0] e [2];
    v = '{I_LDM, I_STM};
    e = '{E_LDM, E_STM};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.allBits = v[i];
      #1;
      total++;
      if (outs() !== e[i]) begin
        bad++;
        $display("FAIL mem[%0d] got=%b exp=%b", i, outs(), e[i]);
      end
    end
  endtask

  task automatic test_nop();
    logic [18:0] v [3];
    v = '{19'b1010_101010101010101,
          19'b1001_000000000000000,
          19'b1110_000000000000001};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.allBits = v[i];
      #1;
      total++;
      if (outs() !== E_NOP) begin
        bad++;
        $display("FAIL nop[%0d] got=%b exp=%b", i, outs(), E_NOP);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] v [4];
    logic [14:0] e [4];
    v = '{I_LDM, I_STM, I_ADD, I_SH3};
    e = '{E_LDM, E_STM, E_ADD, E_SH3};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.allBits = v[i];
      #1;
      total++;
      if (outs() !== e[i]) begin
        bad++;
        $display("FAIL b2b[%0d] got=%b exp=%b", i, outs(), e[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.allBits = I_MASK;
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (outs() !== E_ZERO) begin
      bad++;
      $display("FAIL reset_mid got=%b exp=%b", outs(), E_ZERO);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (outs() !== E_ZERO) begin
      bad++;
      $display("FAIL reset_mid_first got=%b exp=%b", outs(), E_ZERO);
    end
    @(posedge clk);
    #1;
    total++;
    if (outs() !== E_MASK) begin
      bad++;
      $display("FAIL reset_mid_run got=%b exp=%b", outs(), E_MASK);
    end
  endtask

  task automatic test_halt();
    logic [14:0] e_h;
    logic [14:0] e_a;
`ifdef HALT_EN
    e_h = E_ZERO;
    e_a = E_ZERO;
`else
    e_h = E_NOP;
    e_a = E_ADD;
`endif
    @(negedge clk);
    bus.allBits = I_HALT;
    #1;
    total++;
    if (outs() !== e_h) begin
      bad++;
      $display("FAIL halt_insn got=%b exp=%b", outs(), e_h);
    end
    @(negedge clk);
    bus.allBits = I_ADD;
    #1;
    total++;
    if (outs() !== e_a) begin
      bad++;
      $display("FAIL halt_after got=%b exp=%b", outs(), e_a);
    end
    @(negedge clk);
    bus.allBits = I_LDM;
    #1;
    total++;
    if (outs() !== (e_a == E_ZERO ? E_ZERO : E_LDM)) begin
      bad++;
      $display("FAIL halt_sticky got=%b", outs());
    end
    rst = 1'b1;
    #2;
    rst = 1'b0;
    bus.allBits = I_ADD;
    @(posedge clk);
    #1;
    total++;
    if (outs() !== E_ADD) begin
      bad++;
      $display("FAIL halt_cleared got=%b exp=%b", outs(), E_ADD);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.allBits = '0;
    test_reset();
    test_alu();
    test_shift();
    test_mem();
    test_nop();
    test_back_to_back();
    test_reset_mid();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
